// File: rtl/attack_sequencer_pkg.sv
// Shared encodings, phase-length table and immunity window for the attack sequencer.
package attack_sequencer_pkg;

    typedef enum logic [1:0] {
        AtkNone   = 2'b00,
        AtkLight  = 2'b01,
        AtkMedium = 2'b10,
        AtkHeavy  = 2'b11
    } attack_e;

    typedef enum logic [1:0] {
        PhIdle     = 2'b00,
        PhWindup   = 2'b01,
        PhActive   = 2'b10,
        PhRecovery = 2'b11
    } phase_e;

    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0] LIGHT_WINDUP    = 4'd2;
    localparam logic [CNT_W-1:0] LIGHT_ACTIVE    = 4'd2;
    localparam logic [CNT_W-1:0] LIGHT_RECOVERY  = 4'd4;
    localparam logic [CNT_W-1:0] MEDIUM_WINDUP   = 4'd4;
    localparam logic [CNT_W-1:0] MEDIUM_ACTIVE   = 4'd3;
    localparam logic [CNT_W-1:0] MEDIUM_RECOVERY = 4'd8;
    localparam logic [CNT_W-1:0] HEAVY_WINDUP    = 4'd8;
    localparam logic [CNT_W-1:0] HEAVY_ACTIVE    = 4'd4;
    localparam logic [CNT_W-1:0] HEAVY_RECOVERY  = 4'd14;

    localparam int unsigned IMMUNITY_FRAMES = 30;
    localparam int unsigned IMM_W           = 5;

    function automatic logic [CNT_W-1:0] phase_len(input attack_e atk, input phase_e ph);
        logic [CNT_W-1:0] len;
        len = '0;
        case (atk)
            AtkLight: begin
                case (ph)
                    PhWindup:   len = LIGHT_WINDUP;
                    PhActive:   len = LIGHT_ACTIVE;
                    PhRecovery: len = LIGHT_RECOVERY;
                    default:    len = '0;
                endcase
            end
            AtkMedium: begin
                case (ph)
                    PhWindup:   len = MEDIUM_WINDUP;
                    PhActive:   len = MEDIUM_ACTIVE;
                    PhRecovery: len = MEDIUM_RECOVERY;
                    default:    len = '0;
                endcase
            end
            AtkHeavy: begin
                case (ph)
                    PhWindup:   len = HEAVY_WINDUP;
                    PhActive:   len = HEAVY_ACTIVE;
                    PhRecovery: len = HEAVY_RECOVERY;
                    default:    len = '0;
                endcase
            end
            default: len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/attack_sequencer_phase_timer.sv
// phase_timer: loadable frame-tick down-counter; o_done pulses on the tick that takes it 1 -> 0.
module attack_sequencer_phase_timer
    import attack_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_len;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = i_tick && (r_count == CNT_W'(1));

endmodule

// File: rtl/attack_sequencer.sv
// Attack FSM (idle/windup/active/recovery) with one-shot strike pulse.
// Optional HIT_IMMUNITY_EN adds a cross-attack strike lockout window.
module attack_sequencer
    import attack_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_light,
    input  logic       btn_medium,
    input  logic       btn_heavy,
    input  logic       in_range,
    input  logic       game_active,
    output logic [1:0] attack_state,
    output logic [1:0] anim_phase,
    output logic [1:0] attack_type,
    output logic       busy
);

    phase_e           r_state;
    attack_e          r_type;
    logic             r_struck;

    attack_e          w_btn_type;
    attack_e          w_len_type;
    phase_e           w_next_phase;
    logic             w_start;
    logic             w_done;
    logic             w_load;
    logic             w_strike;
    logic             w_immune;
    logic [CNT_W-1:0] w_len;

    always_comb begin
        if (btn_heavy) begin
            w_btn_type = AtkHeavy;
        end else if (btn_medium) begin
            w_btn_type = AtkMedium;
        end else if (btn_light) begin
            w_btn_type = AtkLight;
        end else begin
            w_btn_type = AtkNone;
        end
    end

    always_comb begin
        w_next_phase = PhIdle;
        case (r_state)
            PhIdle:   w_next_phase = PhWindup;
            PhWindup: w_next_phase = PhActive;
            PhActive: w_next_phase = PhRecovery;
            default:  w_next_phase = PhIdle;
        endcase
    end

    assign w_start    = game_active && (r_state == PhIdle) && (w_btn_type != AtkNone);
    assign w_len_type = (r_state == PhIdle) ? w_btn_type : r_type;
    assign w_len      = phase_len(w_len_type, w_next_phase);
    // Recovery needs no reload: its counter has just reached zero on the same tick.
    assign w_load     = w_start ||
                        (game_active && w_done && ((r_state == PhWindup) || (r_state == PhActive)));

    attack_sequencer_phase_timer u_phase_timer (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (frame_tick),
        .i_load  (w_load),
        .i_clear (!game_active),
        .i_len   (w_len),
        .o_done  (w_done)
    );

    assign w_strike = !reset && game_active && (r_state == PhActive) && in_range &&
                      !r_struck && !w_immune;

`ifdef HIT_IMMUNITY_EN
    logic [IMM_W-1:0] r_immunity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_immunity <= '0;
        end else if (w_strike) begin
            r_immunity <= IMM_W'(IMMUNITY_FRAMES);
        end else if (frame_tick && (r_immunity != '0)) begin
            r_immunity <= r_immunity - 1'b1;
        end
    end

    assign w_immune = (r_immunity != '0);
`else
    assign w_immune = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || !game_active) begin
            r_state  <= PhIdle;
            r_type   <= AtkNone;
            r_struck <= 1'b0;
        end else begin
            case (r_state)
                PhIdle: begin
                    if (w_start) begin
                        r_state  <= PhWindup;
                        r_type   <= w_btn_type;
                        r_struck <= 1'b0;
                    end
                end
                PhWindup: begin
                    if (w_done) r_state <= PhActive;
                end
                PhActive: begin
                    if (w_strike) r_struck <= 1'b1;
                    if (w_done) r_state <= PhRecovery;
                end
                PhRecovery: begin
                    if (w_done) begin
                        r_state <= PhIdle;
                        r_type  <= AtkNone;
                    end
                end
                default: r_state <= PhIdle;
            endcase
        end
    end

    assign attack_state = w_strike ? r_type : AtkNone;
    assign anim_phase   = r_state;
    assign attack_type  = r_type;
    assign busy         = (r_state != PhIdle);

endmodule

// File: tb/tb_attack_sequencer.sv
// Directed bench for attack_sequencer; frame_tick fires every 4th clock.
module tb_attack_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_light;
    logic       btn_medium;
    logic       btn_heavy;
    logic       in_range;
    logic       game_active;
    logic [1:0] attack_state;
    logic [1:0] anim_phase;
    logic [1:0] attack_type;
    logic       busy;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         tb_cyc   = 0;

    int         t_wind, t_act, t_rec, n_pulse, pulse_tick, pulse_cyc, act_cyc;
    logic [1:0] pulse_val, type_seen;
    logic       done_flag;

`ifdef HIT_IMMUNITY_EN
    localparam int SecondPulses = 0;
`else
    localparam int SecondPulses = 1;
`endif

    attack_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .btn_light    (btn_light),
        .btn_medium   (btn_medium),
        .btn_heavy    (btn_heavy),
        .in_range     (in_range),
        .game_active  (game_active),
        .attack_state (attack_state),
        .anim_phase   (anim_phase),
        .attack_type  (attack_type),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        tb_cyc++;
        frame_tick = (tb_cyc % 4 == 3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        game_active = 1'b1;
        btn_light = 1'b0;
        btn_medium = 1'b0;
        btn_heavy = 1'b0;
        in_range = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    // mode 0: in_range always high; 1: high only in 3rd active frame; 2: always low.
    task automatic run_attack(input int mode);
        logic started;
        started = 1'b0;
        t_wind = 0; t_act = 0; t_rec = 0; n_pulse = 0;
        pulse_tick = -1; pulse_cyc = -1; act_cyc = 0;
        pulse_val = 2'b00; type_seen = 2'b00; done_flag = 1'b0;
        for (int i = 0; i < 600; i++) begin
            case (mode)
                0:       in_range = 1'b1;
                1:       in_range = (anim_phase == 2'b10) && (t_act == 2);
                default: in_range = 1'b0;
            endcase
            #1;
            if (started && anim_phase == 2'b00) begin
                done_flag = 1'b1;
                break;
            end
            if (anim_phase != 2'b00) begin
                started = 1'b1;
                type_seen = attack_type;
                btn_light = 1'b0;
                btn_medium = 1'b0;
                btn_heavy = 1'b0;
            end
            if (attack_state != 2'b00) begin
                n_pulse++;
                pulse_val = attack_state;
                pulse_tick = t_act;
                pulse_cyc = act_cyc;
            end
            if (anim_phase == 2'b10) act_cyc++;
            if (frame_tick) begin
                case (anim_phase)
                    2'b01:   t_wind++;
                    2'b10:   t_act++;
                    2'b11:   t_rec++;
                    default: ;
                endcase
            end
            cycle();
        end
        in_range = 1'b0;
        check("attack_done", done_flag, 1);
    endtask

    initial begin
        frame_tick = 1'b0;
        reset = 1'b1;
        game_active = 1'b1;
        btn_light = 1'b0;
        btn_medium = 1'b0;
        btn_heavy = 1'b1;
        in_range = 1'b1;
        cycle();
        cycle();
        #1;
        check("rst_phase", anim_phase, 0);
        check("rst_strike", attack_state, 0);
        check("rst_type", attack_type, 0);
        check("rst_busy", busy, 0);

        // Buttons are ignored while the round is not in fight.
        do_reset();
        game_active = 1'b0;
        btn_medium = 1'b1;
        cycle();
        check("inactive_no_start", anim_phase, 0);
        check("inactive_busy", busy, 0);

        // Light attack, in range throughout.
        do_reset();
        btn_light = 1'b1;
        run_attack(0);
        check("light_type", type_seen, 1);
        check("light_windup_frames", t_wind, 2);
        check("light_active_frames", t_act, 2);
        check("light_recovery_frames", t_rec, 4);
        check("light_total_frames", t_wind + t_act + t_rec, 8);
        check("light_pulses", n_pulse, 1);
        check("light_pulse_val", pulse_val, 1);
        check("light_pulse_on_entry", pulse_cyc, 0);

        // Heavy beats light; strike only when range appears in 3rd active frame.
        do_reset();
        btn_heavy = 1'b1;
        btn_light = 1'b1;
        run_attack(1);
        check("heavy_type", type_seen, 3);
        check("heavy_windup_frames", t_wind, 8);
        check("heavy_active_frames", t_act, 4);
        check("heavy_recovery_frames", t_rec, 14);
        check("heavy_pulses", n_pulse, 1);
        check("heavy_pulse_val", pulse_val, 3);
        check("heavy_pulse_frame", pulse_tick, 2);

        // Medium out of range, then a held button restarts one cycle after IDLE.
        do_reset();
        btn_medium = 1'b1;
        run_attack(2);
        check("medium_type", type_seen, 2);
        check("medium_total_frames", t_wind + t_act + t_rec, 15);
        check("medium_recovery_frames", t_rec, 8);
        check("medium_pulses", n_pulse, 0);
        btn_light = 1'b1;
        cycle();
        check("restart_phase", anim_phase, 1);
        check("restart_type", attack_type, 1);
        run_attack(2);
        check("restart_pulses", n_pulse, 0);

        // game_active falls mid-windup of a heavy attack.
        do_reset();
        btn_heavy = 1'b1;
        cycle();
        check("drop_windup", anim_phase, 1);
        btn_heavy = 1'b0;
        in_range = 1'b1;
        repeat (6) cycle();
        game_active = 1'b0;
        #1;
        check("drop_no_strike", attack_state, 0);
        cycle();
        check("drop_phase", anim_phase, 0);
        check("drop_busy", busy, 0);
        check("drop_type", attack_type, 0);
        game_active = 1'b1;
        in_range = 1'b0;
        cycle();

        // Reset lands on what would be the strike cycle.
        do_reset();
        btn_medium = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (anim_phase == 2'b10) break;
            cycle();
            btn_medium = 1'b0;
        end
        check("rst_reach_active", anim_phase, 2);
        in_range = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_strike_cycle", attack_state, 0);
        cycle();
        check("rst_mid_phase", anim_phase, 0);
        check("rst_mid_type", attack_type, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_strike", attack_state, 0);
        reset = 1'b0;
        in_range = 1'b0;

        // Three light attacks: back-to-back pair, then one after a 30+ frame gap.
        do_reset();
        btn_light = 1'b1;
        run_attack(0);
        check("imm_first_pulses", n_pulse, 1);
        btn_light = 1'b1;
        run_attack(0);
        check("imm_second_pulses", n_pulse, SecondPulses);
        repeat (130) cycle();
        btn_light = 1'b1;
        run_attack(0);
        check("imm_third_pulses", n_pulse, 1);
        check("imm_third_val", pulse_val, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/attack_sequencer.md
ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: frame_tick  input  1  one-clk pulse per video frame; all phase timing counts these.
REQ-004 SHALL have port: btn_light / btn_medium / btn_heavy  input  1 each  debounced player attack buttons, level.
REQ-005 SHALL have port: in_range  input  1  attacker hitbox overlaps opponent this cycle.
REQ-006 SHALL have port: game_active  input  1  high while round state is fight (00).
REQ-007 SHALL have port: attack_state  output  2  strike pulse to health stage: 00 none, 01 light, 10 medium, 11 heavy.
REQ-008 SHALL have port: anim_phase  output  2  00 idle, 01 windup, 10 active, 11 recovery.
REQ-009 SHALL have port: attack_type  output  2  type of attack in progress, 00 when idle.
REQ-010 SHALL have port: busy  output  1  high in any state except IDLE.

Function
REQ-011 FSM states SHALL be IDLE, WINDUP, ACTIVE, RECOVERY; anim_phase SHALL equal the state encoding.
REQ-012 In IDLE with game_active=1, any button high SHALL start an attack next cycle (enter WINDUP); priority heavy > medium > light.
REQ-013 Buttons SHALL be ignored outside IDLE; no input buffering.
REQ-014 Phase lengths in frames (windup/active/recovery): light 2/2/4, medium 4/3/8, heavy 8/4/14.
REQ-015 Phase counter SHALL load phase length on entry and decrement only on frame_tick; phase SHALL advance on the frame_tick that takes counter from 1 to 0.
REQ-016 RECOVERY end SHALL return to IDLE; a held button SHALL start a new attack no earlier than the following cycle.
REQ-017 In ACTIVE, the first clk cycle with in_range=1 and game_active=1 SHALL drive attack_state=attack_type for exactly one cycle; at most one strike per attack.
REQ-018 attack_state SHALL be 00 in every other cycle, so the downstream health stage applies damage once per hit.
REQ-019 game_active falling SHALL force IDLE next cycle from any state, clearing counters and strike flag.
REQ-020 frame_tick coincident with strike cycle SHALL both strike and decrement normally.

Reset
REQ-021 On reset: state IDLE, attack_state 00, anim_phase 00, attack_type 00, busy 0, counters 0, strike flag 0, immunity counter 0.
REQ-022 Reset SHALL override all other inputs, including mid-attack and strike cycle (attack_state 00 that cycle's output).

Configuration
REQ-023 Macro HIT_IMMUNITY_EN defined: after a strike, further strikes SHALL be suppressed for 30 frame_ticks (across attacks); attacks still animate normally.
REQ-024 Macro HIT_IMMUNITY_EN undefined: no immunity counter exists; every attack may strike per REQ-017.

Structure
REQ-025 Shared package SHALL hold: attack type encodings, phase encodings, the 9 phase-length constants, IMMUNITY_FRAMES=30.
REQ-026 One sub-module, phase_timer (loadable frame-tick down-counter with done pulse), SHALL be used; FSM stays in attack_sequencer.

Verification
REQ-027 Light press, in_range=1 throughout, frame_tick every 4 clk -> WINDUP 2 frames, one attack_state=01 pulse on ACTIVE entry cycle, IDLE after 8 frames total.
REQ-028 Heavy+light pressed same cycle -> attack_type=11; in_range raised only in 3rd active frame -> single 11 pulse then.
REQ-029 Medium press, in_range=0 whole attack -> attack_state never nonzero, full 15-frame sequence completes.
REQ-030 game_active dropped mid-WINDUP of heavy -> IDLE next cycle, busy=0, no strike; reset asserted during ACTIVE -> all outputs 00/0 next cycle.
REQ-031 With HIT_IMMUNITY_EN: two back-to-back light attacks in range -> first strikes, second (within 30 frames) emits no pulse; third after 30 frames strikes. Without macro -> all three strike.
